// File: rtl/ts_demuxer_if.sv
// Muxed TS input and demuxed per-channel output bundle for ts_demuxer.
// The master side drives the muxed stream and observes the demuxed one.
interface ts_demuxer_if;
    logic [7:0] DATA_IN;
    logic       D_VALID_IN;
    logic       P_SYNC_IN;
    logic [7:0] DATA_OUT;
    logic [3:0] D_VALID_OUT;
    logic [3:0] P_SYNC_OUT;

    modport master (
        output DATA_IN, D_VALID_IN, P_SYNC_IN,
        input  DATA_OUT, D_VALID_OUT, P_SYNC_OUT
    );

    modport slave (
        input  DATA_IN, D_VALID_IN, P_SYNC_IN,
        output DATA_OUT, D_VALID_OUT, P_SYNC_OUT
    );
endinterface

// File: rtl/ts_demuxer.sv
// Splits the tagged 4-channel pseudo-TS stream back into per-tuner streams, restoring the 0x47 sync,
// and keeps per-channel packet counts, activity timers and a saturating error count.
module ts_demuxer #(
    parameter int unsigned PKT_LEN     = 188,
    parameter logic [7:0]  TAG_BASE    = 8'h44,
    parameter int unsigned GAP_MAX     = 255,
    parameter int unsigned ACT_TIMEOUT = 27_000_000
) (
    input  logic         clk_27,
    input  logic         RST,
    ts_demuxer_if.slave  ts,
    input  logic [1:0]   PKT_CNT_SEL,
    output logic [15:0]  PKT_CNT,
    output logic [7:0]   ERR_CNT,
    output logic         ERR_STB,
    output logic [3:0]   CH_ACTIVE
);
    localparam int BC_W  = $clog2(PKT_LEN + 1);
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam int ACT_W = 25;
    localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(PKT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_TIMEOUT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       ch_reg, ch_next;
    logic [BC_W-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]       data_out_reg, data_out_next;
    logic [3:0]       dv_out_reg, dv_out_next;
    logic [3:0]       ps_out_reg, ps_out_next;
    logic             err_next;
    logic             err_stb_reg;
    logic [7:0]       err_cnt_reg;
    logic [15:0]      pkt_cnt_out_reg;
    logic             pkt_done;
    logic             start_sync;

    logic             in_byte;
    logic             in_sync;
    logic [7:0]       tag_off;
    logic             tag_ok;
    logic [1:0]       tag_ch;

    logic [3:0][15:0] pkt_cnt_all;

    assign in_byte = ts.D_VALID_IN;
    assign in_sync = ts.D_VALID_IN & ts.P_SYNC_IN;
    assign tag_off = ts.DATA_IN - TAG_BASE;
    assign tag_ok  = (tag_off < 8'd4);
    assign tag_ch  = tag_off[1:0];

    always_comb begin
        state_next    = state_reg;
        ch_next       = ch_reg;
        byte_cnt_next = byte_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        data_out_next = data_out_reg;
        dv_out_next   = 4'b0000;
        ps_out_next   = 4'b0000;
        err_next      = 1'b0;
        pkt_done      = 1'b0;
        start_sync    = 1'b0;

        case (state_reg)
            HUNT, DROP: begin
                if (in_sync) begin
                    start_sync = 1'b1;
                end
            end
            PAYLOAD: begin
                if (in_sync) begin
                    // Truncated packet: the new sync byte starts the next packet without loss.
                    err_next   = 1'b1;
                    start_sync = 1'b1;
                end else if (in_byte) begin
                    data_out_next = ts.DATA_IN;
                    dv_out_next   = 4'b0001 << ch_reg;
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    gap_cnt_next  = '0;
                    if (byte_cnt_reg == LAST_IDX) begin
                        pkt_done   = 1'b1;
                        state_next = HUNT;
                    end
                end else if (gap_cnt_reg == GAP_LAST) begin
                    err_next     = 1'b1;
                    gap_cnt_next = '0;
                    state_next   = HUNT;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase

        // A bad re-tag after a truncation still counts as a single error for the cycle.
        if (start_sync) begin
            gap_cnt_next = '0;
            if (tag_ok) begin
                ch_next       = tag_ch;
                data_out_next = 8'h47;
                dv_out_next   = 4'b0001 << tag_ch;
                ps_out_next   = 4'b0001 << tag_ch;
                byte_cnt_next = BC_W'(1);
                state_next    = PAYLOAD;
            end else begin
                err_next   = 1'b1;
                state_next = DROP;
            end
        end
    end

    always_ff @(posedge clk_27 or negedge RST) begin
        if (!RST) begin
            state_reg       <= HUNT;
            ch_reg          <= '0;
            byte_cnt_reg    <= '0;
            gap_cnt_reg     <= '0;
            data_out_reg    <= '0;
            dv_out_reg      <= '0;
            ps_out_reg      <= '0;
            err_stb_reg     <= 1'b0;
            err_cnt_reg     <= '0;
            pkt_cnt_out_reg <= '0;
        end else begin
            state_reg       <= state_next;
            ch_reg          <= ch_next;
            byte_cnt_reg    <= byte_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            data_out_reg    <= data_out_next;
            dv_out_reg      <= dv_out_next;
            ps_out_reg      <= ps_out_next;
            err_stb_reg     <= err_next;
            if (err_next && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
            pkt_cnt_out_reg <= pkt_cnt_all[PKT_CNT_SEL];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [15:0]      pkt_cnt_reg;
        logic [ACT_W-1:0] act_tmr_reg;

        always_ff @(posedge clk_27 or negedge RST) begin
            if (!RST) begin
                pkt_cnt_reg <= '0;
                act_tmr_reg <= '0;
            end else if (pkt_done && (ch_reg == 2'(gi))) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                act_tmr_reg <= ACT_LOAD;
            end else if (act_tmr_reg != '0) begin
                act_tmr_reg <= act_tmr_reg - 1'b1;
            end
        end

        assign pkt_cnt_all[gi] = pkt_cnt_reg;
        assign CH_ACTIVE[gi]   = (act_tmr_reg != '0);
    end

    assign ts.DATA_OUT    = data_out_reg;
    assign ts.D_VALID_OUT = dv_out_reg;
    assign ts.P_SYNC_OUT  = ps_out_reg;
    assign PKT_CNT        = pkt_cnt_out_reg;
    assign ERR_CNT        = err_cnt_reg;
    assign ERR_STB        = err_stb_reg;
endmodule

// File: tb/tb_ts_demuxer.sv
// Directed bench for ts_demuxer: a packet table for the main paths plus hand sequences for
// truncation, idle gap, error saturation, reset mid-packet and activity timeout.
module tb_ts_demuxer;
    localparam int PKT_LEN = 188;
    localparam int GAP_MAX = 255;
    localparam int ACT_TO  = 1000;

    logic        clk_27 = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  PKT_CNT_SEL = 2'd0;
    logic [15:0] PKT_CNT;
    logic [7:0]  ERR_CNT;
    logic        ERR_STB;
    logic [3:0]  CH_ACTIVE;

    ts_demuxer_if ts_bus();

    ts_demuxer #(
        .PKT_LEN(PKT_LEN), .TAG_BASE(8'h44), .GAP_MAX(GAP_MAX), .ACT_TIMEOUT(ACT_TO)
    ) dut (
        .clk_27(clk_27), .RST(RST), .ts(ts_bus), .PKT_CNT_SEL(PKT_CNT_SEL),
        .PKT_CNT(PKT_CNT), .ERR_CNT(ERR_CNT), .ERR_STB(ERR_STB), .CH_ACTIVE(CH_ACTIVE)
    );

    always #5 clk_27 = ~clk_27;

    int tests = 0;
    int fails = 0;
    int rx_bytes [4] = '{0, 0, 0, 0};
    int rx_syncs [4] = '{0, 0, 0, 0};
    int rx_sum   [4] = '{0, 0, 0, 0};
    int exp_sum  [4] = '{0, 0, 0, 0};
    int err_pulses = 0;
    int sync_bad = 0;
    int onehot_bad = 0;

    // Output monitor: tallies what each channel receives.
    always @(negedge clk_27) begin
        if (RST) begin
            for (int c = 0; c < 4; c++) begin
                if (ts_bus.D_VALID_OUT[c]) begin
                    rx_bytes[c] <= rx_bytes[c] + 1;
                    rx_sum[c]   <= rx_sum[c] + int'(ts_bus.DATA_OUT);
                end
                if (ts_bus.P_SYNC_OUT[c]) begin
                    rx_syncs[c] <= rx_syncs[c] + 1;
                    if (ts_bus.DATA_OUT != 8'h47 || !ts_bus.D_VALID_OUT[c]) sync_bad <= sync_bad + 1;
                end
            end
            if ($countones(ts_bus.D_VALID_OUT) > 1) onehot_bad <= onehot_bad + 1;
            if (ERR_STB) err_pulses <= err_pulses + 1;
        end
    end

    task automatic check(input string name, input int idx, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, actual, expected);
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk_27);
        #1;
        ts_bus.D_VALID_IN = v;
        ts_bus.P_SYNC_IN  = s;
        ts_bus.DATA_IN    = d;
    endtask

    // Idle cycles carry junk data and a raised sync that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 8'hA5);
    endtask

    function automatic logic [7:0] pay(input int i, input logic [7:0] tag);
        return 8'((i * 7 + int'(tag) * 13) & 255);
    endfunction

    // Sends n bytes of a packet; fwd_ch >= 0 means those bytes are expected on that channel.
    task automatic send_pkt(input logic [7:0] tag, input int n, input bit toggle, input int fwd_ch);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (toggle && i > 0) idle(1);
            if (toggle && i == 91) idle(GAP_MAX - 2);
            d = (i == 0) ? tag : pay(i, tag);
            cycle(1'b1, (i == 0), d);
            if (fwd_ch >= 0) exp_sum[fwd_ch] += (i == 0) ? 32'h47 : int'(d);
        end
    endtask

    task automatic read_pkt(input int c, output int v);
        PKT_CNT_SEL = 2'(c);
        idle(2);
        v = int'(PKT_CNT);
    endtask

    function automatic int total_rx();
        return rx_bytes[0] + rx_bytes[1] + rx_bytes[2] + rx_bytes[3];
    endfunction

    typedef struct {
        logic [7:0] tag;
        bit         toggle;
        int         idle_after;
        int         exp_ch;
        int         exp_ch_bytes;
        int         exp_ch_pkts;
        int         exp_total;
        int         exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int first;
        int c;
        int v;

        vecs[0] = '{8'h44, 1'b0, 0, 0, 188, 1, 188,  0};
        vecs[1] = '{8'h45, 1'b0, 0, 1, 188, 1, 376,  0};
        vecs[2] = '{8'h46, 1'b0, 0, 2, 188, 1, 564,  0};
        vecs[3] = '{8'h47, 1'b0, 4, 3, 188, 1, 752,  0};
        vecs[4] = '{8'h46, 1'b1, 4, 2, 376, 2, 940,  0};
        vecs[5] = '{8'h50, 1'b0, 4, -1,  0, 0, 940,  1};
        vecs[6] = '{8'h45, 1'b0, 4, 1, 376, 2, 1128, 1};

        ts_bus.D_VALID_IN = 1'b0;
        ts_bus.P_SYNC_IN  = 1'b0;
        ts_bus.DATA_IN    = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_27);
        #1;
        check("rst_dv", 0, int'(ts_bus.D_VALID_OUT), 0);
        check("rst_err_cnt", 0, int'(ERR_CNT), 0);
        check("rst_active", 0, int'(CH_ACTIVE), 0);
        RST = 1'b1;
        idle(3);
        check("rst_pkt_cnt", 0, int'(PKT_CNT), 0);
        check("rst_data_out", 0, int'(ts_bus.DATA_OUT), 0);

        // Packet table: back-to-back channels, gappy channel 2, bad tag, good channel 1
        first = 0;
        for (int k = 0; k < 7; k++) begin
            send_pkt(vecs[k].tag, PKT_LEN, vecs[k].toggle, vecs[k].exp_ch);
            if (vecs[k].idle_after > 0) begin
                idle(vecs[k].idle_after);
                check("total_bytes", k, total_rx(), vecs[k].exp_total);
                check("err_cnt", k, int'(ERR_CNT), vecs[k].exp_err);
                check("err_pulses", k, err_pulses, vecs[k].exp_err);
                for (int j = first; j <= k; j++) begin
                    if (vecs[j].exp_ch >= 0) begin
                        c = vecs[j].exp_ch;
                        check("ch_bytes", j, rx_bytes[c], vecs[j].exp_ch_bytes);
                        check("ch_syncs", j, rx_syncs[c], vecs[j].exp_ch_pkts);
                        check("ch_sum", j, rx_sum[c], exp_sum[c]);
                        check("ch_active", j, int'(CH_ACTIVE[c]), 1);
                        read_pkt(c, v);
                        check("pkt_cnt", j, v, vecs[j].exp_ch_pkts);
                    end
                end
                first = k + 1;
            end
        end

        // Truncation at byte 100 of a channel 0 packet, re-tagged as channel 3
        send_pkt(8'h44, 100, 1'b0, 0);
        send_pkt(8'h47, PKT_LEN, 1'b0, 3);
        idle(3);
        check("trunc_err_cnt", 0, int'(ERR_CNT), 2);
        check("trunc_err_pulses", 0, err_pulses, 2);
        check("trunc_ch0_bytes", 0, rx_bytes[0], 288);
        check("trunc_ch3_bytes", 0, rx_bytes[3], 376);
        check("trunc_ch3_sum", 0, rx_sum[3], exp_sum[3]);
        read_pkt(0, v);
        check("trunc_pkt0", 0, v, 1);
        read_pkt(3, v);
        check("trunc_pkt3", 0, v, 2);

        // Idle gap: GAP_MAX-1 idle cycles are tolerated, the GAP_MAX-th is an error
        send_pkt(8'h45, 10, 1'b0, 1);
        idle(GAP_MAX - 1);
        check("gap_below_max", 0, err_pulses, 2);
        idle(3);
        check("gap_err_pulses", 0, err_pulses, 3);
        check("gap_err_cnt", 0, int'(ERR_CNT), 3);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h11);
        idle(2);
        check("gap_hunt_discard", 0, rx_bytes[1], 386);
        check("gap_hunt_no_err", 0, err_pulses, 3);

        // Forced errors saturate the counter while every strobe is still issued
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 8'h00);
        idle(3);
        check("sat_err_cnt", 0, int'(ERR_CNT), 255);
        check("sat_err_pulses", 0, err_pulses, 303);
        check("sat_total_bytes", 0, total_rx(), 1128 + 100 + 188 + 10);

        // Reset at byte 50 of a channel 2 packet, then a clean packet
        send_pkt(8'h46, 50, 1'b0, 2);
        idle(1);
        #2 RST = 1'b0;
        #1;
        check("midrst_err_cnt", 0, int'(ERR_CNT), 0);
        check("midrst_active", 0, int'(CH_ACTIVE), 0);
        check("midrst_dv", 0, int'(ts_bus.D_VALID_OUT), 0);
        check("midrst_pkt_cnt", 0, int'(PKT_CNT), 0);
        idle(3);
        #2 RST = 1'b1;
        idle(2);
        send_pkt(8'h46, PKT_LEN, 1'b0, 2);
        idle(4);
        check("post_rst_ch2_bytes", 0, rx_bytes[2], 376 + 50 + 188);
        check("post_rst_ch2_sum", 0, rx_sum[2], exp_sum[2]);
        check("post_rst_err_pulses", 0, err_pulses, 303);
        check("post_rst_err_cnt", 0, int'(ERR_CNT), 0);
        read_pkt(2, v);
        check("post_rst_pkt2", 0, v, 1);
        idle(ACT_TO - 6);
        check("act_last_cycle", 0, int'(CH_ACTIVE), 4'b0100);
        idle(1);
        check("act_timeout", 0, int'(CH_ACTIVE), 0);

        check("sync_byte_bad", 0, sync_bad, 0);
        check("onehot_bad", 0, onehot_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
